pattern_detector_param: RTL
===========================

Name: pattern_detector_param

Overview:
Parametrised successor to the fixed 2-bit Mealy pattern recogniser. It detects an arbitrary PATTERN_LEN-bit serial pattern on a 1-bit input stream. It provides:
- a Mealy (same-cycle) match output and a registered Moore-style output,
- selectable overlapping or non-overlapping detection,
- enable, synchronous clear, and fill-progress visibility.

It sits directly behind a serial input sampler and drives event counters and interrupt logic.

Parameters:
PATTERN_LEN, 2, pattern length in bits; legal range 2..32.
PATTERN, 2'b01, PATTERN_LEN-bit pattern. PATTERN[PATTERN_LEN-1] is the first bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window restarts after each match.
COUNT_W, 8, width of match_count (used only with PATDET_COUNT_EN).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
en  input  1  1 = sample a this cycle
clear  input  1  synchronous clear of detector state
a  input  1  serial data bit
y  output  1  Mealy match: combinational, valid in the same cycle as the final pattern bit
y_q  output  1  y registered: high one cycle after y
fill  output  $clog2(PATTERN_LEN)  number of valid history bits, 0..PATTERN_LEN-1
match_count  output  COUNT_W  saturating match count (present only with PATDET_COUNT_EN)

Behaviour:
- State registers:
  - hist[PATTERN_LEN-2:0]: last accepted bits; hist[PATTERN_LEN-2] is the oldest.
  - fill counter.
  - y_q.
  - match_count.
- Reset (reset=0, asynchronous): hist=0, fill=0, y_q=0, match_count=0. y therefore evaluates to 0.
- Mealy output: y = en & ~clear & (fill==PATTERN_LEN-1) & ({hist,a}==PATTERN). No match is possible until PATTERN_LEN-1 bits have been accepted since reset or clear.
- Accepted cycle (en=1, clear=0):
  - hist <= {hist[PATTERN_LEN-3:0],a}; for PATTERN_LEN=2, hist <= a.
  - fill <= min(fill+1, PATTERN_LEN-1).
  - If y=1 and OVERLAP=0: fill <= 0 instead (history contents become don't-care).
- Idle cycle (en=0, clear=0): hist and fill hold; y=0.
- Clear (clear=1): fill<=0, y_q<=0, match_count<=0 on the next edge; y=0 in that cycle. clear has priority over en.
- Every edge: y_q <= y, except on clear, where y_q <= 0.
- Latency:
  - y: 0 cycles after the last pattern bit.
  - y_q: 1 cycle after the last pattern bit.
- Reset asserted mid-pattern: all state is lost immediately; the pattern must be received in full again after release.
- Reset release is asynchronous at the port. The first accepted bit is the first en=1 edge after release.
- Default parameters reproduce the legacy "01" recogniser exactly.

Optional Feature:
PATDET_COUNT_EN
- Defined:
  - match_count port exists.
  - Increments by 1 on every edge where y=1.
  - Saturates at 2^COUNT_W-1 (no wrap).
  - Cleared by reset and by clear.
- Undefined: match_count port and counter logic are absent; all other behaviour is unchanged.

Test Plan:
1. Defaults (LEN=2, PAT=01). Reset low for 10 ns, then a=0,1,0,1,1 with en=1 -> y=1 on bits 2 and 4 only; y_q=1 one cycle after each.
2. LEN=3, PAT=101, OVERLAP=1, stream 1,0,1,0,1 -> y on bits 3 and 5. Same stream with OVERLAP=0 -> y on bit 3 only; fill after bit 5 = 2.
3. LEN=4, PAT=1011, stream 1,0,[en=0 for 3 cycles, a toggling],1,1 -> en=0 cycles ignored; y=1 on the final bit; fill holds at 2 during the gap.
4. LEN=3, PAT=101. Send 1,0, pull reset low mid-cycle, release, then send 1 -> y=0 (fill=1). Subsequent 0,1 -> y=1.
5. Clear with en=1 on the cycle the final pattern bit arrives -> y=0, y_q=0 next cycle, fill=0.
6. With PATDET_COUNT_EN, COUNT_W=2, defaults, five "01" pairs -> match_count reads 1,2,3,3,3. Clear -> 0.

Source files
------------

// File: rtl/pattern_detector_param.sv
// pattern_detector_param
//   Detects a PATTERN_LEN-bit serial pattern on a 1-bit input stream.
//   PATTERN[PATTERN_LEN-1] is the first bit received. The default parameters
//   give the same behaviour as the fixed "01" Mealy recogniser.
//
// Optional build macro: PATDET_COUNT_EN
//   When defined, the match_count port and its saturating counter are present.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset (0 = reset)
//   en           in   1 = accept input bit a this cycle
//   clear        in   synchronous clear of detector state; has priority over en
//   a            in   serial data bit
//   y            out  Mealy match, valid in the same cycle as the final bit
//   y_q          out  y delayed by one clock
//   fill         out  number of valid history bits, 0..PATTERN_LEN-1
//   match_count  out  saturating match count (PATDET_COUNT_EN only)
module pattern_detector_param #(
  parameter int unsigned             PATTERN_LEN = 2,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 2'b01,
  parameter bit                      OVERLAP     = 1'b1,
  parameter int unsigned             COUNT_W     = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            clear,
  input  logic                            a,
  output logic                            y,
  output logic                            y_q,
  output logic [$clog2(PATTERN_LEN)-1:0]  fill
`ifdef PATDET_COUNT_EN
  ,
  output logic [COUNT_W-1:0]              match_count
`endif
);

  localparam int unsigned         FILL_W   = $clog2(PATTERN_LEN);
  localparam logic [FILL_W-1:0]   FILL_MAX = FILL_W'(PATTERN_LEN - 1);

  logic [PATTERN_LEN-2:0] r_hist;
  logic [FILL_W-1:0]      r_fill;
  logic                   r_y_q;

  logic [PATTERN_LEN-1:0] w_window;
  logic                   w_accept;
  logic                   w_full;
  logic                   w_match;

  // Candidate window: stored history followed by the bit on the wire now.
  assign w_window = {r_hist, a};
  assign w_accept = en & ~clear;
  assign w_full   = (r_fill == FILL_MAX);
  assign w_match  = w_accept & w_full & (w_window == PATTERN);

  assign y    = w_match;
  assign y_q  = r_y_q;
  assign fill = r_fill;

  // History shift uses the low bits of the window so PATTERN_LEN=2
  // (a one-bit history) needs no special case.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_y_q  <= 1'b0;
    end else if (clear) begin
      r_fill <= '0;
      r_y_q  <= 1'b0;
    end else begin
      r_y_q <= w_match;
      if (w_accept) begin
        r_hist <= w_window[PATTERN_LEN-2:0];
        if (w_match && !OVERLAP) begin
          r_fill <= '0;
        end else if (!w_full) begin
          r_fill <= r_fill + FILL_W'(1);
        end
      end
    end
  end

`ifdef PATDET_COUNT_EN
  logic [COUNT_W-1:0] r_count;

  assign match_count = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (w_match && (r_count != '1)) begin
      r_count <= r_count + COUNT_W'(1);
    end
  end
`endif

endmodule
